// File: rtl/pc_ctrl_pkg.sv
// Shared types and default parameters for the PC fetch controller.
package pc_ctrl_pkg;

    localparam int          PC_W_DEF      = 16;
    localparam int          OFF_W_DEF     = 8;
    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
    localparam int          MAX_WAIT_DEF  = 15;
    localparam int          DATA_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT,
        ST_DRAIN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// IMEM request/response bus and downstream instruction handshake.
// Valid/ready: a transfer happens on any rising edge where the source's
// valid (IMEM_REQ / IMEM_VALID / INSTR_VALID) and the sink's accept
// (IMEM_GNT / always / INSTR_READY) are both high; the source holds its
// payload stable until that edge.
interface pc_fetch_ctrl_if #(
    parameter int PC_W = pc_ctrl_pkg::PC_W_DEF
);
    logic                          IMEM_REQ;
    logic [PC_W-1:0]               IMEM_ADDR;
    logic                          IMEM_GNT;
    logic                          IMEM_VALID;
    logic [pc_ctrl_pkg::DATA_W-1:0] IMEM_DATA;
    logic [pc_ctrl_pkg::DATA_W-1:0] INSTR;
    logic                          INSTR_VALID;
    logic                          INSTR_READY;

    modport master (
        output IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID,
        input  IMEM_GNT, IMEM_VALID, IMEM_DATA, INSTR_READY
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID,
        output IMEM_GNT, IMEM_VALID, IMEM_DATA, INSTR_READY
    );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC select: PC+1 for sequential flow, PC+sext(OFFSET) for a branch.
module pc_next_calc
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic [OFF_W-1:0] i_offset,
    input  logic             i_branch,
    output logic [PC_W-1:0]  o_pc_next
);
    logic [PC_W-1:0] w_off_sext;

    assign w_off_sext = {{(PC_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};
    // Both sums wrap naturally at PC_W bits.
    assign o_pc_next  = i_branch ? (i_pc + w_off_sext) : (i_pc + 1'b1);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and IMEM fetch sequencer with downstream valid/ready output.
// Optional performance counters are enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              OFF_W     = OFF_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter int              MAX_WAIT  = MAX_WAIT_DEF
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    pc_fetch_ctrl_if.master  bus,
    input  logic             BRANCH,
    input  logic [OFF_W-1:0] OFFSET,
    output logic             BRANCH_ACK,
    output logic [PC_W-1:0]  PC,
    output logic             FETCH_ERR,
    output state_t           DBG_STATE
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [15:0]      PERF_INSTR,
    output logic [15:0]      PERF_STALL
`endif
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic                r_instr_valid;
    logic                r_imem_req;
    logic                r_branch_ack;
    logic                r_fetch_err;
    logic [CNT_W-1:0]    r_wait_cnt;

    logic                w_branch_ok;
    logic                w_accept;
    logic                w_timeout;
    logic [PC_W-1:0]     w_pc_next;

    assign w_branch_ok = BRANCH && (r_state != ST_IDLE) && (r_state != ST_ERR);
    assign w_accept    = (r_state == ST_OUT) && bus.INSTR_READY && !w_branch_ok;
    assign w_timeout   = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next (
        .i_pc      (r_pc),
        .i_offset  (OFFSET),
        .i_branch  (w_branch_ok),
        .o_pc_next (w_pc_next)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_VEC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_branch_ack  <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_branch_ack <= w_branch_ok;
            if (w_branch_ok || w_accept) begin
                r_pc <= w_pc_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (EN) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.IMEM_GNT) begin
                        r_imem_req <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= w_branch_ok ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_branch_ok) begin
                        // A response arriving with the branch is already consumed.
                        r_wait_cnt <= '0;
                        if (bus.IMEM_VALID) begin
                            r_state    <= ST_REQ;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.IMEM_VALID) begin
                        r_instr       <= bus.IMEM_DATA;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_OUT;
                    end else if (w_timeout) begin
                        r_state     <= ST_ERR;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (w_branch_ok) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_REQ;
                        r_imem_req    <= 1'b1;
                    end else if (bus.INSTR_READY) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= EN ? ST_REQ : ST_IDLE;
                        r_imem_req    <= EN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.IMEM_VALID) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                    end else if (w_timeout) begin
                        r_state     <= ST_ERR;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    r_imem_req <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IMEM_REQ    = r_imem_req;
    assign bus.IMEM_ADDR   = r_pc;
    assign bus.INSTR       = r_instr;
    assign bus.INSTR_VALID = r_instr_valid;
    assign BRANCH_ACK      = r_branch_ack;
    assign PC              = r_pc;
    assign FETCH_ERR       = r_fetch_err;
    assign DBG_STATE       = r_state;

`ifdef PC_FETCH_PERF_EN
    logic [15:0] r_perf_instr;
    logic [15:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == ST_WAIT) || ((r_state == ST_OUT) && !bus.INSTR_READY);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && (r_perf_instr != 16'hFFFF)) begin
                r_perf_instr <= r_perf_instr + 16'd1;
            end
            if (w_stall && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign PERF_INSTR = r_perf_instr;
    assign PERF_STALL = r_perf_stall;
`else
    // Counters are absent in this build; the core above is unchanged.
`endif
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequences the program counter and the instruction-memory fetch handshake. Holds the architectural PC and issues fetch requests to IMEM. Applies PC+1 or branch PC+sext(OFFSET) updates and delivers fetched words downstream with a valid/ready handshake. Sits between the PC arithmetic and the decode stage.

Parameters:
PC_W, 16, PC and IMEM address width
OFF_W, 8, branch offset width, two's complement
RESET_VEC, 16'h0000, PC value loaded at reset
MAX_WAIT, 15, maximum WAIT-state cycles before fetch timeout

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  synchronous reset, active low
EN  in  1  fetch enable
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  PC_W  fetch address (equals PC)
IMEM_GNT  in  1  request accepted this cycle
IMEM_VALID  in  1  read data valid
IMEM_DATA  in  16  read data
INSTR  out  16  fetched instruction
INSTR_VALID  out  1  INSTR valid
INSTR_READY  in  1  downstream accepts INSTR
BRANCH  in  1  branch request, single-cycle
OFFSET  in  OFF_W  branch offset
BRANCH_ACK  out  1  one-cycle pulse: branch applied
PC  out  PC_W  current PC
FETCH_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (RESET_N=0 at a CLK edge): state IDLE, PC=RESET_VEC, INSTR=0, and INSTR_VALID, IMEM_REQ, BRANCH_ACK and FETCH_ERR all 0. Wait counter is 0. Reset overrides everything mid-operation, and any in-flight response is ignored.
- States:
  - IDLE: goes to REQ when EN=1.
  - REQ: IMEM_REQ=1, IMEM_ADDR=PC. IMEM_GNT=1 goes to WAIT.
  - WAIT: counter increments each cycle. IMEM_VALID=1 captures IMEM_DATA into INSTR, sets INSTR_VALID=1 next cycle and goes to OUT. Counter reaching MAX_WAIT goes to ERR.
  - OUT: INSTR and INSTR_VALID are held stable until INSTR_READY=1. On the handshake, PC<=PC+1, INSTR_VALID<=0, and the next state is REQ if EN=1, else IDLE.
  - DRAIN: waits for the discarded IMEM_VALID (with timeout), then goes to REQ.
  - ERR: FETCH_ERR=1, IMEM_REQ=0. Only reset exits.
- Branch, in any state except IDLE and ERR: PC<=PC+sext(OFFSET), modulo 2^PC_W. BRANCH_ACK=1 the next cycle.
  - In REQ with IMEM_GNT=0: stays in REQ with the new address.
  - In REQ with IMEM_GNT=1, or in WAIT: goes to DRAIN, and the response is discarded (not delivered).
  - In OUT: INSTR_VALID<=0 and goes to REQ. Branch beats INSTR_READY in the same cycle: that instruction is dropped and PC+1 is not applied.
  - BRANCH in IDLE or ERR is ignored, with no ACK.
- Arithmetic: PC+1 and branch targets wrap modulo 2^16. For example, 16'hFFFF+1=16'h0000 and 16'h0002+sext(8'hFE)=16'h0000.
- EN=0 only takes effect at the IDLE decision points. An outstanding fetch completes.
- Latency: REQ with same-cycle GNT plus same-cycle VALID gives INSTR_VALID 2 cycles after REQ assertion. Best-case throughput is one instruction per 3 cycles.

Optional Feature:
PC_FETCH_PERF_EN
- Defined: adds output ports PERF_INSTR (16) and PERF_STALL (16).
  - PERF_INSTR counts OUT handshakes.
  - PERF_STALL counts WAIT cycles plus OUT cycles with INSTR_READY=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package pc_ctrl_pkg holds:
  - state enum (IDLE, REQ, WAIT, OUT, DRAIN, ERR);
  - PC_W and OFF_W defaults and RESET_VEC.
- One sub-module, pc_next_calc: combinational PC+1 / PC+sext(OFFSET) select. It is instantiated once.

Test Plan:
- Reset, then EN=1, with GNT immediate and VALID one cycle after GNT carrying 16'hA5A5 → IMEM_ADDR=0, INSTR=16'hA5A5 with INSTR_VALID; after READY, PC=1 and IMEM_ADDR=1 in the next REQ.
- PC=16'h0010, BRANCH with OFFSET=8'hF0 while in OUT with READY=1 → instruction dropped, PC=16'h0000, BRANCH_ACK pulse, next IMEM_ADDR=16'h0000.
- BRANCH with OFFSET=8'h04 during WAIT at PC=16'h0020 → DRAIN, late VALID data not delivered, next request address 16'h0024.
- PC=16'hFFFF, delivered instruction accepted → PC=16'h0000 (wrap).
- GNT, then no VALID for 15 cycles → FETCH_ERR=1, IMEM_REQ=0, BRANCH ignored; RESET_N=0 clears FETCH_ERR and PC returns to RESET_VEC.
- READY held low for 5 cycles → INSTR and INSTR_VALID stable throughout. With PC_FETCH_PERF_EN defined, PERF_STALL increases by 5.
